// File: rtl/video_scanline_aligner.sv
// video_scanline_aligner
//   Sits after the mono/colour converter. Delays the raw sync/blank signals by
//   SYNC_DELAY pixel-enable cycles so they line up with the converter output.
//   Then one output register stage:
//     - blanks pixels during hblank/vblank
//     - darkens alternate lines according to a per-frame latched scanline mode
//   Optional feature macro: VIDEO_SCANLINE_INTERLACE_EN
//     When defined, the dimmed line set alternates from frame to frame.
//   SYNC_DELAY legal range: 1..8.
`timescale 1ns/1ps

module video_scanline_aligner #(
    parameter int SYNC_DELAY = 3
) (
    input  logic       clk_vid,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic [1:0] scanline_mode,
    input  logic [7:0] R_IN,
    input  logic [7:0] G_IN,
    input  logic [7:0] B_IN,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       hblank_in,
    input  logic       vblank_in,
    output logic [7:0] R_OUT,
    output logic [7:0] G_OUT,
    output logic [7:0] B_OUT,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       hblank_out,
    output logic       vblank_out,
    output logic       de_out
);

    // Sync tap bit positions: {hsync, vsync, hblank, vblank}
    localparam int HS = 3;
    localparam int VS = 2;
    localparam int HB = 1;
    localparam int VB = 0;

    logic [3:0] sync_tap [SYNC_DELAY];
    logic [3:0] aligned;
    logic       aligned_blank;
    logic       h_rise;
    logic       v_rise;
    logic       line_parity;
    logic       parity_nxt;
    logic [1:0] mode_q;
    logic [1:0] mode_nxt;
    logic       vsync_parity;
    logic [7:0] r_px;
    logic [7:0] g_px;
    logic [7:0] b_px;

    // Per-channel darkening. Mode 0 returns the pixel unchanged.
    // The mode 1 result is x - x/4, which is always <= x, so it cannot wrap.
    function automatic logic [7:0] dim_px(input logic [7:0] x, input logic [1:0] m);
        logic [7:0] y;
        case (m)
            2'd1:    y = x - (x >> 2);
            2'd2:    y = x >> 1;
            2'd3:    y = x >> 2;
            default: y = x;
        endcase
        return y;
    endfunction

    // Sync delay line: tap[SYNC_DELAY-1] lines up with the pixel on R/G/B_IN.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            for (int i = 0; i < SYNC_DELAY; i++) sync_tap[i] <= '0;
        end else if (ce_pix) begin
            sync_tap[0] <= {hsync_in, vsync_in, hblank_in, vblank_in};
            for (int i = 1; i < SYNC_DELAY; i++) sync_tap[i] <= sync_tap[i-1];
        end
    end

    assign aligned       = sync_tap[SYNC_DELAY-1];
    assign aligned_blank = aligned[HB] | aligned[VB];

    // The sync output registers hold the previous aligned value.
    // That gives rising-edge detection without extra state.
    assign h_rise = aligned[HS] & ~hsync_out;
    assign v_rise = aligned[VS] & ~vsync_out;

`ifdef VIDEO_SCANLINE_INTERLACE_EN
    logic frame_phase;

    // Frame phase flips every frame, so the dimmed line set alternates.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            frame_phase <= 1'b0;
        end else if (ce_pix && v_rise) begin
            frame_phase <= ~frame_phase;
        end
    end

    // Parity restarts at the new (toggled) frame phase.
    assign vsync_parity = ~frame_phase;
`else
    assign vsync_parity = 1'b0;
`endif

    // Next line parity and mode.
    // On a vsync edge the parity is reloaded and any hsync edge in the same
    // cycle is ignored, so vsync wins.
    always_comb begin
        parity_nxt = line_parity;
        mode_nxt   = mode_q;
        if (v_rise) begin
            parity_nxt = vsync_parity;
            mode_nxt   = scanline_mode;
        end else if (h_rise) begin
            parity_nxt = ~line_parity;
        end
    end

    // Line parity and frame-latched mode registers.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            line_parity <= 1'b0;
            mode_q      <= 2'd0;
        end else if (ce_pix) begin
            line_parity <= parity_nxt;
            mode_q      <= mode_nxt;
        end
    end

    // Pixel shaping. Blanking forces black; odd-parity lines are dimmed.
    always_comb begin
        r_px = R_IN;
        g_px = G_IN;
        b_px = B_IN;
        if (aligned_blank) begin
            r_px = 8'd0;
            g_px = 8'd0;
            b_px = 8'd0;
        end else if (line_parity && (mode_q != 2'd0)) begin
            r_px = dim_px(R_IN, mode_q);
            g_px = dim_px(G_IN, mode_q);
            b_px = dim_px(B_IN, mode_q);
        end
    end

    // Output stage: pixel and sync leave together, one enable after alignment.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            R_OUT      <= 8'd0;
            G_OUT      <= 8'd0;
            B_OUT      <= 8'd0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblank_out <= 1'b0;
            vblank_out <= 1'b0;
            de_out     <= 1'b0;
        end else if (ce_pix) begin
            R_OUT      <= r_px;
            G_OUT      <= g_px;
            B_OUT      <= b_px;
            hsync_out  <= aligned[HS];
            vsync_out  <= aligned[VS];
            hblank_out <= aligned[HB];
            vblank_out <= aligned[VB];
            de_out     <= ~aligned_blank;
        end
    end

endmodule

// File: tb/tb_video_scanline_aligner.sv
// tb_video_scanline_aligner
//   Lockstep scoreboard for video_scanline_aligner.
//   Follows VIDEO_SCANLINE_INTERLACE_EN when the same define is given to the bench.
`timescale 1ns/1ps

module tb_video_scanline_aligner;

    localparam int SD = 3;

`ifdef VIDEO_SCANLINE_INTERLACE_EN
    localparam bit IL = 1'b1;
`else
    localparam bit IL = 1'b0;
`endif

    logic       clk_vid = 1'b0;
    logic       reset;
    logic       ce_pix;
    logic [1:0] scanline_mode;
    logic [7:0] R_IN;
    logic [7:0] G_IN;
    logic [7:0] B_IN;
    logic       hsync_in;
    logic       vsync_in;
    logic       hblank_in;
    logic       vblank_in;
    logic [7:0] R_OUT;
    logic [7:0] G_OUT;
    logic [7:0] B_OUT;
    logic       hsync_out;
    logic       vsync_out;
    logic       hblank_out;
    logic       vblank_out;
    logic       de_out;

    video_scanline_aligner #(.SYNC_DELAY(SD)) dut (
        .clk_vid       (clk_vid),
        .reset         (reset),
        .ce_pix        (ce_pix),
        .scanline_mode (scanline_mode),
        .R_IN          (R_IN),
        .G_IN          (G_IN),
        .B_IN          (B_IN),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .hblank_in     (hblank_in),
        .vblank_in     (vblank_in),
        .R_OUT         (R_OUT),
        .G_OUT         (G_OUT),
        .B_OUT         (B_OUT),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out),
        .hblank_out    (hblank_out),
        .vblank_out    (vblank_out),
        .de_out        (de_out)
    );

    // ---------------- clock ----------------
    always #5 clk_vid = ~clk_vid;

    // Output packing: {R, G, B, hsync, vsync, hblank, vblank, de}
    logic [28:0] obs;
    assign obs = {R_OUT, G_OUT, B_OUT, hsync_out, vsync_out, hblank_out, vblank_out, de_out};

    // ---------------- scoreboard state ----------------
    logic [28:0] exp_q[$];
    logic [28:0] last_exp = '0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [1:0]  mode_sel = 2'd0;
    int          ce_div = 1;
    logic [23:0] last_rgb = '0;
    logic        blank_leak = 1'b0;

    // Reference model state
    logic [3:0]  m_hist[$];
    logic        m_par;
    logic        m_fp;
    logic        m_prev_h;
    logic        m_prev_v;
    logic [1:0]  m_mode;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [7:0] m_dim(input logic [7:0] x, input logic [1:0] m);
        case (m)
            2'd1:    return x - x / 4;
            2'd2:    return x / 2;
            2'd3:    return x / 4;
            default: return x;
        endcase
    endfunction

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < SD; i++) m_hist.push_back(4'h0);
        m_par    = 1'b0;
        m_fp     = 1'b0;
        m_prev_h = 1'b0;
        m_prev_v = 1'b0;
        m_mode   = 2'd0;
    endtask

    task automatic model_push(input logic [7:0] r, g, b, input logic h, v, hb, vb,
                              input logic [1:0] md, output logic [28:0] e);
        logic [3:0] a;
        logic       blank;
        logic [7:0] yr, yg, yb;
        m_hist.push_back({h, v, hb, vb});
        a     = m_hist.pop_front();
        blank = a[1] | a[0];
        yr = blank ? 8'h00 : (m_par ? m_dim(r, m_mode) : r);
        yg = blank ? 8'h00 : (m_par ? m_dim(g, m_mode) : g);
        yb = blank ? 8'h00 : (m_par ? m_dim(b, m_mode) : b);
        e  = {yr, yg, yb, a[3], a[2], a[1], a[0], ~blank};
        if (a[2] && !m_prev_v) begin
            m_mode = md;
            m_fp   = ~m_fp;
            m_par  = IL ? m_fp : 1'b0;
        end else if (a[3] && !m_prev_h) begin
            m_par = ~m_par;
        end
        m_prev_h = a[3];
        m_prev_v = a[2];
    endtask

    // ---------------- driver ----------------
    // One clock: drive, predict, wait for the edge, then compare.
    task automatic step(input logic rst, input logic ce, input logic [7:0] r, g, b,
                        input logic h, v, hb, vb);
        logic [28:0] e;
        reset = rst; ce_pix = ce; scanline_mode = mode_sel;
        R_IN = r; G_IN = g; B_IN = b;
        hsync_in = h; vsync_in = v; hblank_in = hb; vblank_in = vb;
        if (rst) begin
            model_reset();
            exp_q.push_back('0);
        end else if (ce) begin
            model_push(r, g, b, h, v, hb, vb, mode_sel, e);
            exp_q.push_back(e);
        end
        @(posedge clk_vid);
        #1;
        if (rst || ce) begin
            last_exp = exp_q.pop_front();
            check("out", obs, last_exp);
        end else begin
            check("hold", obs, last_exp);
        end
        if (de_out) last_rgb = {R_OUT, G_OUT, B_OUT};
        else if ({R_OUT, G_OUT, B_OUT} != 24'h0) blank_leak = 1'b1;
    endtask

    // One enabled pixel, preceded by ce_div-1 disabled cycles with junk inputs.
    task automatic pix(input logic [7:0] p, input logic h, v, hb, vb);
        for (int k = 1; k < ce_div; k++)
            step(1'b0, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        step(1'b0, 1'b1, p, p, p, h, v, hb, vb);
    endtask

    // One line: 6 sync positions, 8 active positions, then 5 porch positions.
    // Pixels trail the sync/blank inputs by SD positions.
    task automatic run_line(input logic [7:0] px);
        logic [7:0] p;
        last_rgb = '0;
        for (int i = 0; i < 19; i++) begin
            p = (i >= 6 + SD && i <= 13 + SD) ? px : 8'hFF;
            pix(p, (i == 1 || i == 2), 1'b0, !(i >= 6 && i <= 13), 1'b0);
        end
        check("hblank_rgb", {8'h0, R_OUT, G_OUT, B_OUT}, 32'h0);
        check("hblank_de", {31'h0, de_out}, 32'h0);
    endtask

    // Vertical blank with a vsync pulse.
    // If sim is set, an hsync pulse rises in the same cycle as vsync.
    task automatic frame_start(input logic sim);
        for (int i = 0; i < 8; i++)
            pix(8'hFF, sim && (i == 1 || i == 2), (i >= 1 && i <= 3), 1'b1, 1'b1);
        check("vblank_rgb", {8'h0, R_OUT, G_OUT, B_OUT}, 32'h0);
        check("vblank_de", {31'h0, de_out}, 32'h0);
        check("vblank_out", {31'h0, vblank_out}, 32'h1);
    endtask

    // Start a frame in mode md, then check the first two lines for input 0xC8.
    task automatic frame_check(input string tag, input logic [1:0] md, input logic sim,
                               input logic [7:0] e1_off, e2_off, e1_on, e2_on);
        logic [7:0] e1, e2;
        e1 = IL ? e1_on : e1_off;
        e2 = IL ? e2_on : e2_off;
        mode_sel = md;
        frame_start(sim);
        run_line(8'hC8);
        check({tag, "_line1"}, {8'h0, last_rgb}, {8'h0, e1, e1, e1});
        run_line(8'hC8);
        check({tag, "_line2"}, {8'h0, last_rgb}, {8'h0, e2, e2, e2});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        step(1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'hAA, 8'h55, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1);
        check("reset_all", {3'h0, obs}, 32'h0);

        // Latency: hsync at cycle 10 and pixel at cycle 13 emerge together.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, (i == 13) ? 8'h80 : 8'h00, 8'h00, 8'h00, (i == 10), 1'b0, 1'b0, 1'b0);
            if (i == 12) check("lat_hs_early", {31'h0, hsync_out}, 32'h0);
            if (i == 13) begin
                check("lat_hs", {31'h0, hsync_out}, 32'h1);
                check("lat_r", {24'h0, R_OUT}, 32'h80);
            end
            if (i == 14) check("lat_hs_width", {31'h0, hsync_out}, 32'h0);
        end

        // Dimming modes
        frame_check("m2", 2'd2, 1'b0, 8'h64, 8'hC8, 8'hC8, 8'h64);
        frame_check("m3", 2'd3, 1'b0, 8'h32, 8'hC8, 8'h32, 8'hC8);
        frame_check("m1", 2'd1, 1'b0, 8'h96, 8'hC8, 8'hC8, 8'h96);

        // Mode latch: a mid-frame change waits for the next vsync.
        frame_check("m0", 2'd0, 1'b0, 8'hC8, 8'hC8, 8'hC8, 8'hC8);
        mode_sel = 2'd2;
        run_line(8'hC8);
        check("latch_mid1", {8'h0, last_rgb}, 32'hC8C8C8);
        run_line(8'hC8);
        check("latch_mid2", {8'h0, last_rgb}, 32'hC8C8C8);
        frame_check("latch_next", 2'd2, 1'b0, 8'h64, 8'hC8, 8'hC8, 8'h64);

        // ce_pix gating: one enable every third cycle
        ce_div = 3;
        frame_check("ce3", 2'd2, 1'b0, 8'h64, 8'hC8, 8'h64, 8'hC8);

        // Reset with ce_pix low, then mode is off until the next vsync.
        step(1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        check("reset_ce0", {3'h0, obs}, 32'h0);
        run_line(8'hC8);
        check("post_reset_line", {8'h0, last_rgb}, 32'hC8C8C8);
        frame_check("post_reset", 2'd2, 1'b0, 8'h64, 8'hC8, 8'hC8, 8'h64);

        // hsync and vsync rising on the same enabled cycle
        ce_div = 1;
        frame_check("sim_a", 2'd2, 1'b1, 8'h64, 8'hC8, 8'h64, 8'hC8);
        frame_check("sim_b", 2'd2, 1'b1, 8'h64, 8'hC8, 8'hC8, 8'h64);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            mode_sel = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        check("blank_leak", {31'h0, blank_leak}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
